pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, PC width in words (range 8..32).
REQ-002 Parameter DISP_CH, default 2, number of syscall display channels (1..8).
REQ-003 Parameter HALT_CODE, default 32'ha, syscall code that halts the core.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  advance enable; 0 = stall, all state held.
REQ-007 instr  in  32  current instruction word; [15:0] branch offset, [25:0] jump index.
REQ-008 branch_taken, j, jal, jr, syscall  in  1 each  decoded control strobes.
REQ-009 rf_a  in  32  rs read value: jr target, syscall code ($v0).
REQ-010 rf_b  in  32  display operand ($a0).
REQ-011 go  in  1  resume pulse while halted.
REQ-012 pc  out  ADDR_W  current PC (word address).
REQ-013 pc_plus1  out  ADDR_W  pc+1, combinational; link value for jal.
REQ-014 halted  out  1  high while in HALT state.
REQ-015 disp  out  DISP_CH*32  display registers, channel k at bits [32k+31:32k].
REQ-016 disp_valid  out  DISP_CH  one-cycle pulse per channel on update.
REQ-017 retired_cnt, taken_cnt  out  32 each  statistics (see Configuration).

Function
REQ-018 Two-state FSM: RUN, HALT; only RUN with en=1 advances pc.
REQ-019 Next-PC priority in RUN: jr -> rf_a[ADDR_W-1:0]; else j or jal -> jump target; else branch_taken -> pc+1+sext(instr[15:0]); else pc+1.
REQ-020 Jump target = {pc_plus1[ADDR_W-1:26], instr[25:0]} when ADDR_W>26, else instr[ADDR_W-1:0].
REQ-021 All PC arithmetic is modulo 2^ADDR_W; pc of all-ones + 1 wraps to 0.
REQ-022 syscall with rf_a==HALT_CODE, en=1: pc held, state -> HALT next edge, halted=1 from that edge; control strobes ignored that cycle.
REQ-023 syscall with 1<=rf_a<=DISP_CH, en=1: disp channel rf_a-1 <= rf_b, disp_valid bit pulses one cycle, pc <= pc+1.
REQ-024 syscall with any other code: no display update, pc <= pc+1.
REQ-025 syscall takes precedence over jr/j/jal/branch_taken in the same cycle.
REQ-026 HALT: pc, disp held, disp_valid=0; go=1 -> pc <= pc+1, state RUN next edge; en ignored in HALT.
REQ-027 go in RUN ignored; syscall/strobes with en=0 ignored (no pulse, no state change).
REQ-028 disp holds last value indefinitely between updates.

Reset
REQ-029 rst=1 at a clock edge overrides all inputs including go and syscall.
REQ-030 Reset values: pc=0, state RUN, halted=0, disp all 0, disp_valid=0, retired_cnt=0, taken_cnt=0.
REQ-031 Reset mid-HALT or mid-stall returns to RUN at pc=0 the following cycle.

Configuration
REQ-032 Macro PC_SEQ_STAT_EN defined: retired_cnt increments each RUN cycle with en=1 and no halting syscall; taken_cnt increments when pc loads a non-sequential target (jr, j, jal, branch_taken); both saturate at 32'hffffffff.
REQ-033 Macro PC_SEQ_STAT_EN undefined: counters not built, retired_cnt and taken_cnt driven constant 0; ports retained.

Verification
REQ-034 Reset, en=1, no strobes 4 cycles -> pc 0,1,2,3,4; halted=0.
REQ-035 pc=5, instr[15:0]=16'hfffd, branch_taken=1 -> pc=3; same with jr=1, rf_a=32'h40 -> pc=32'h40 (jr wins).
REQ-036 syscall, rf_a=1, rf_b=32'h1234 -> disp ch0=32'h1234, disp_valid=2'b01 one cycle; rf_a=7 with DISP_CH=2 -> no update, pc+1.
REQ-037 syscall rf_a=10 at pc=8 -> halted=1, pc stays 8 for 5 cycles with en=1; go=1 -> pc=9, halted=0.
REQ-038 ADDR_W=8, pc=8'hff, no strobes -> pc=0; en=0 with jal=1 -> pc unchanged.
REQ-039 rst asserted while halted with disp ch1 nonzero -> next cycle pc=0, halted=0, disp=0; with PC_SEQ_STAT_EN, 3 sequential + 1 taken jump -> retired_cnt=4, taken_cnt=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: RUN/HALT FSM, next-PC selection, syscall halt and display channels.
// Define PC_SEQ_STAT_EN to build the saturating retired/taken statistics counters.
module pc_sequencer #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DISP_CH   = 2,
  parameter logic [31:0] HALT_CODE = 32'ha
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [31:0]             instr,
  input  logic                    branch_taken,
  input  logic                    j,
  input  logic                    jal,
  input  logic                    jr,
  input  logic                    syscall,
  input  logic [31:0]             rf_a,
  input  logic [31:0]             rf_b,
  input  logic                    go,
  output logic [ADDR_W-1:0]       pc,
  output logic [ADDR_W-1:0]       pc_plus1,
  output logic                    halted,
  output logic [DISP_CH*32-1:0]   disp,
  output logic [DISP_CH-1:0]      disp_valid,
  output logic [31:0]             retired_cnt,
  output logic [31:0]             taken_cnt
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [DISP_CH*32-1:0] disp_q, disp_d;
  logic [DISP_CH-1:0]    dv_q, dv_d;

  logic [31:0]           off_sext;
  logic [ADDR_W-1:0]     br_target;
  logic [ADDR_W-1:0]     jmp_target;
  logic                  sys_halt;
  logic                  sys_disp;
  logic                  retire;
  logic                  taken;

  assign pc_plus1  = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign off_sext  = {{16{instr[15]}}, instr[15:0]};
  assign br_target = pc_plus1 + off_sext[ADDR_W-1:0];

  // Narrow PCs take the jump index directly; wide PCs keep the upper segment of pc+1.
  generate
    if (ADDR_W > 26) begin : g_jt_wide
      assign jmp_target = {pc_plus1[ADDR_W-1:26], instr[25:0]};
    end else begin : g_jt_narrow
      assign jmp_target = instr[ADDR_W-1:0];
    end
  endgenerate

  assign sys_halt = (rf_a == HALT_CODE);
  assign sys_disp = (rf_a >= 32'd1) && (rf_a <= 32'(DISP_CH));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    disp_d  = disp_q;
    dv_d    = '0;
    retire  = 1'b0;
    taken   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (en) begin
          if (syscall) begin
            // A halting syscall freezes pc; every other code just steps past it.
            if (sys_halt) begin
              state_d = ST_HALT;
            end else begin
              retire = 1'b1;
              pc_d   = pc_plus1;
              for (int k = 0; k < int'(DISP_CH); k++) begin
                if (sys_disp && (rf_a == 32'(k + 1))) begin
                  disp_d[k*32 +: 32] = rf_b;
                  dv_d[k]            = 1'b1;
                end
              end
            end
          end else begin
            retire = 1'b1;
            if (jr) begin
              pc_d  = rf_a[ADDR_W-1:0];
              taken = 1'b1;
            end else if (j || jal) begin
              pc_d  = jmp_target;
              taken = 1'b1;
            end else if (branch_taken) begin
              pc_d  = br_target;
              taken = 1'b1;
            end else begin
              pc_d  = pc_plus1;
            end
          end
        end
      end
      ST_HALT: begin
        if (go) begin
          pc_d    = pc_plus1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      disp_q  <= '0;
      dv_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      disp_q  <= disp_d;
      dv_q    <= dv_d;
    end
  end

  assign pc         = pc_q;
  assign halted     = (state_q == ST_HALT);
  assign disp       = disp_q;
  assign disp_valid = dv_q;

`ifdef PC_SEQ_STAT_EN
  logic [31:0] retired_q;
  logic [31:0] taken_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else begin
      if (retire && (retired_q != 32'hffff_ffff)) retired_q <= retired_q + 32'd1;
      if (taken && (taken_q != 32'hffff_ffff))    taken_q   <= taken_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign taken_cnt   = taken_q;

  logic unused_ok;
  assign unused_ok = ^{instr, off_sext};
`else
  assign retired_cnt = '0;
  assign taken_cnt   = '0;

  logic unused_ok;
  assign unused_ok = ^{instr, off_sext, retire, taken};
`endif

endmodule
